// File: rtl/bcd_seg_counter.sv
// Four-digit BCD up/down counter with a multiplexed, active-low seven-segment
// display driver. Optional leading-zero blanking applies to the upper three digits.
module bcd_seg_counter #(
    parameter int SCAN_BITS = 14,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        ovf
);

    logic [3:0][3:0]       count_reg;
    logic                  ovf_reg;
    logic [SCAN_BITS-1:0]  scan_reg;
    logic [1:0]            idx_reg;
    logic [6:0]            seg_reg;
    logic [3:0]            an_reg;

    logic [3:0][3:0]       inc_next;
    logic [3:0][3:0]       dec_next;
    logic                  carry;
    logic                  borrow;
    logic                  lz_run;
    logic [3:0]            blank;
    logic [3:0][6:0]       digit_seg;
    logic [6:0]            seg_next;
    logic [3:0]            an_next;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
    always_comb begin
        inc_next = count_reg;
        dec_next = count_reg;
        carry    = 1'b1;
        borrow   = 1'b1;
        lz_run   = 1'b1;
        blank    = '0;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                inc_next[i] = (count_reg[i] == 4'd9) ? 4'd0 : count_reg[i] + 4'd1;
                carry       = (count_reg[i] == 4'd9);
            end
            if (borrow) begin
                dec_next[i] = (count_reg[i] == 4'd0) ? 4'd9 : count_reg[i] - 4'd1;
                borrow      = (count_reg[i] == 4'd0);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            lz_run   = lz_run && (count_reg[i] == 4'd0);
            blank[i] = BLANK_LZ && (i != 0) && lz_run;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_seg[gi] = blank[gi] ? 7'h7F : seg_pattern(count_reg[gi]);
        end
    endgenerate

    assign seg_next = digit_seg[idx_reg];
    assign an_next  = ~(4'b0001 << idx_reg);

    // clr outranks a coincident tick and never signals a wrap.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (clr) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (tick && en) begin
            count_reg <= up ? inc_next : dec_next;
            ovf_reg   <= up ? carry : borrow;
        end else begin
            ovf_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            scan_reg <= '0;
            idx_reg  <= 2'd0;
            seg_reg  <= 7'h7F;
            an_reg   <= 4'hF;
        end else begin
            scan_reg <= scan_reg + SCAN_BITS'(1);
            if (&scan_reg) begin
                idx_reg <= idx_reg + 2'd1;
            end
            seg_reg  <= seg_next;
            an_reg   <= an_next;
        end
    end

    assign count_bcd = count_reg;
    assign ovf       = ovf_reg;
    assign seg       = seg_reg;
    assign an        = an_reg;

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Directed self-checking bench for bcd_seg_counter with a short scan period.
module tb_bcd_seg_counter;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        tick;
    logic        en;
    logic        up;
    logic        clr;
    logic [15:0] count_bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ovf;

    int checks = 0;
    int passed = 0;
    int edges;
    bit ovf_seen;

    bcd_seg_counter #(.SCAN_BITS(2), .BLANK_LZ(1'b1)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .tick      (tick),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .count_bcd (count_bcd),
        .seg       (seg),
        .an        (an),
        .ovf       (ovf)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    always @(negedge clk_in) begin
        if (ovf === 1'b1) ovf_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk_in);
        tick = 1'b0;
    endtask

    initial begin
        logic [6:0] seg_tab [4];
        logic [3:0] an_exp;
        int         k;
        seg_tab = '{7'h12, 7'h40, 7'h30, 7'h7F};

        rst = 1'b1; tick = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;
        #12;
        chk("reset_count", count_bcd, 16'h0000);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_ovf", ovf, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("first_edge_an", an, 4'hE);
        chk("first_edge_seg", seg, 7'h40);

        en = 1'b1; up = 1'b1; ovf_seen = 1'b0;
        ticks(12);
        chk("count_12", count_bcd, 16'h0012);
        step();
        chk("no_ovf_12", ovf_seen, 1'b0);

        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_0000", count_bcd, 16'h0000);

        up = 1'b0; ticks(1);
        chk("down_wrap_count", count_bcd, 16'h9999);
        chk("down_wrap_ovf", ovf, 1'b1);
        step();
        chk("down_wrap_ovf_drop", ovf, 1'b0);

        up = 1'b1; ticks(1);
        chk("up_wrap_count", count_bcd, 16'h0000);
        chk("up_wrap_ovf", ovf, 1'b1);
        step();
        chk("up_wrap_ovf_drop", ovf, 1'b0);

        up = 1'b0; ticks(1);
        chk("down_wrap2_count", count_bcd, 16'h9999);
        chk("down_wrap2_ovf", ovf, 1'b1);
        ticks(1);
        chk("down_9998", count_bcd, 16'h9998);
        chk("down_9998_ovf", ovf, 1'b0);

        clr = 1'b1; step(); clr = 1'b0;
        up = 1'b1; ticks(9);
        chk("up_0009", count_bcd, 16'h0009);
        ticks(1);
        chk("up_0010", count_bcd, 16'h0010);
        up = 1'b0; ticks(1);
        chk("down_0009", count_bcd, 16'h0009);
        en = 1'b0; ticks(5);
        chk("en_off_hold", count_bcd, 16'h0009);
        en = 1'b1; up = 1'b1; ticks(1);
        chk("up_again_0010", count_bcd, 16'h0010);
        ticks(89);
        chk("up_0099", count_bcd, 16'h0099);
        ticks(1);
        chk("up_0100", count_bcd, 16'h0100);

        clr = 1'b1; tick = 1'b1; up = 1'b0;
        step();
        chk("clr_tick_count", count_bcd, 16'h0000);
        chk("clr_tick_ovf", ovf, 1'b0);
        step();
        chk("clr_tick_at0_count", count_bcd, 16'h0000);
        chk("clr_tick_at0_ovf", ovf, 1'b0);
        clr = 1'b0; tick = 1'b0;

        up = 1'b1; ticks(305);
        chk("up_0305", count_bcd, 16'h0305);
        step();
        for (int c = 0; c < 16; c++) begin
            step();
            k = ((edges - 1) / 4) % 4;
            an_exp = 4'hF ^ (4'b0001 << k);
            chk($sformatf("scan_an_%0d", c), an, an_exp);
            chk($sformatf("scan_seg_%0d", c), seg, seg_tab[k]);
        end

        clr = 1'b1; step(); clr = 1'b0;
        ticks(42);
        chk("up_0042", count_bcd, 16'h0042);
        #2;
        rst = 1'b1; tick = 1'b1;
        #1;
        chk("async_rst_count", count_bcd, 16'h0000);
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_ovf", ovf, 1'b0);
        step();
        rst = 1'b0; tick = 1'b0;
        step();
        chk("post_rst_an", an, 4'hE);
        chk("post_rst_seg", seg, 7'h40);
        chk("post_rst_count", count_bcd, 16'h0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
